// File: rtl/lc3_reg_file.sv
// lc3_reg_file: LC-3 register file R0..R7 with NZP condition codes and the
// branch-enable bit used by the control FSM.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, the register
// being written drives BUS onto its output in the same cycle.
module lc3_reg_file #(
  parameter int          DATA_W    = 16,
  parameter logic [2:0]  RESET_NZP = 3'b010
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] BUS,
  input  logic [15:0]       IR,
  input  logic              LD_REG,
  input  logic              DRMUX,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  output logic [DATA_W-1:0] reg1_out,
  output logic [DATA_W-1:0] reg2_out,
  output logic [DATA_W-1:0] reg3_out,
  output logic [DATA_W-1:0] reg4_out,
  output logic [DATA_W-1:0] reg5_out,
  output logic [DATA_W-1:0] reg6_out,
  output logic [DATA_W-1:0] reg7_out,
  output logic [DATA_W-1:0] reg8_out,
  output logic [2:0]        nzp_out,
  output logic              BEN,
  output logic [2:0]        dr_sel
);

  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] view [8];
  logic [2:0]        nzpNext;
  logic              benNext;

  // Destination decode: linkage instructions force R7, otherwise IR[11:9].
  always_comb begin
    dr_sel = DRMUX ? 3'b111 : IR[11:9];
  end

  // Condition codes from the bus value and branch enable from the held flags.
  always_comb begin
    nzpNext = {BUS[DATA_W-1], (BUS == '0), (~BUS[DATA_W-1]) & (BUS != '0)};
    benNext = (IR[11] & nzp_out[2]) | (IR[10] & nzp_out[1]) | (IR[9] & nzp_out[0]);
  end

  // Register storage: reset clears everything, a load writes only R[dr_sel].
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (LD_REG) begin
      regs[dr_sel] <= BUS;
    end
  end

  // Flag state: NZP and BEN load independently; BEN sees the pre-edge NZP.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      nzp_out <= RESET_NZP;
      BEN     <= 1'b0;
    end else begin
      if (LD_CC)  nzp_out <= nzpNext;
      if (LD_BEN) BEN     <= benNext;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Output view with same-cycle forwarding of BUS onto the register being written.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      view[i] = (LD_REG && (dr_sel == 3'(i))) ? BUS : regs[i];
    end
  end
`else
  // Output view is the plain flop contents.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      view[i] = regs[i];
    end
  end
`endif

  assign reg1_out = view[0];
  assign reg2_out = view[1];
  assign reg3_out = view[2];
  assign reg4_out = view[3];
  assign reg5_out = view[4];
  assign reg6_out = view[5];
  assign reg7_out = view[6];
  assign reg8_out = view[7];

endmodule

// File: tb/tb_lc3_reg_file.sv
// tb_lc3_reg_file: directed and randomized checks of lc3_reg_file against a
// behavioural model of the register file, flags and branch enable.
module tb_lc3_reg_file;

  logic        Clk;
  logic        Reset_n;
  logic [15:0] BUS;
  logic [15:0] IR;
  logic        LD_REG;
  logic        DRMUX;
  logic        LD_CC;
  logic        LD_BEN;
  logic [15:0] regOut [8];
  logic [2:0]  nzp_out;
  logic        BEN;
  logic [2:0]  dr_sel;

  logic [15:0] mReg [8];
  logic [2:0]  mNzp;
  logic        mBen;

  int checks = 0;
  int passes = 0;

  lc3_reg_file dut (
    .Clk(Clk), .Reset_n(Reset_n), .BUS(BUS), .IR(IR),
    .LD_REG(LD_REG), .DRMUX(DRMUX), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .reg1_out(regOut[0]), .reg2_out(regOut[1]), .reg3_out(regOut[2]),
    .reg4_out(regOut[3]), .reg5_out(regOut[4]), .reg6_out(regOut[5]),
    .reg7_out(regOut[6]), .reg8_out(regOut[7]),
    .nzp_out(nzp_out), .BEN(BEN), .dr_sel(dr_sel)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic applyStimulus(input logic ldReg, input logic drMux, input logic ldCc,
                               input logic ldBen, input logic [15:0] bus, input logic [15:0] ir);
    LD_REG = ldReg; DRMUX = drMux; LD_CC = ldCc; LD_BEN = ldBen; BUS = bus; IR = ir;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("%s R%0d", tag, i), regOut[i], mReg[i]);
    checkOutput({tag, " nzp"}, {13'd0, nzp_out}, {13'd0, mNzp});
    checkOutput({tag, " ben"}, {15'd0, BEN}, {15'd0, mBen});
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mReg[i] = 16'h0000;
    mNzp = 3'b010;
    mBen = 1'b0;
  endtask

  // One clock edge: model commits using the inputs held across the edge.
  task automatic tick();
    int dst;
    @(posedge Clk);
    dst = DRMUX ? 7 : int'(IR[11:9]);
    if (LD_BEN) mBen = |(IR[11:9] & mNzp);
    if (LD_REG) mReg[dst] = BUS;
    if (LD_CC) begin
      if ($signed(BUS) < 0)  mNzp = 3'b100;
      else if (BUS == 0)     mNzp = 3'b010;
      else                   mNzp = 3'b001;
    end
    #1;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    Reset_n = 1'b0;
    modelReset();
    #12;
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    checkAll("initial reset");

    // Random loads, then asynchronous reset between edges.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1'($urandom), 1, 1, 16'($urandom), 16'($urandom));
      tick();
    end
    #2;
    Reset_n = 1'b0;
    modelReset();
    #1;
    checkAll("async reset");
    #1;
    Reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    tick();
    checkAll("post reset");

    // Write decode through IR[11:9] and through the R7 override.
    applyStimulus(1, 0, 0, 0, 16'hBEEF, 16'h0A00);
    #1;
    checkOutput("dr_sel ir", {13'd0, dr_sel}, 16'd5);
    tick();
    checkOutput("decode R5", regOut[5], 16'hBEEF);
    checkAll("decode ir");
    applyStimulus(1, 1, 0, 0, 16'hBEEF, 16'h0A00);
    #1;
    checkOutput("dr_sel r7", {13'd0, dr_sel}, 16'd7);
    tick();
    checkOutput("decode R7", regOut[7], 16'hBEEF);
    checkAll("decode r7");

    // Condition code generation for negative, zero, positive.
    applyStimulus(0, 0, 1, 0, 16'h8000, 16'h0000);
    tick();
    checkOutput("cc neg", {13'd0, nzp_out}, 16'd4);
    applyStimulus(0, 0, 1, 0, 16'h0000, 16'h0000);
    tick();
    checkOutput("cc zero", {13'd0, nzp_out}, 16'd2);
    applyStimulus(0, 0, 1, 0, 16'h0001, 16'h0000);
    tick();
    checkOutput("cc pos", {13'd0, nzp_out}, 16'd1);

    // BEN uses the flags held before the edge, not the ones loaded with it.
    applyStimulus(0, 0, 1, 1, 16'h0000, 16'h0E00);
    tick();
    checkOutput("ben old p", {15'd0, BEN}, 16'd1);
    checkOutput("ben nzp z", {13'd0, nzp_out}, 16'd2);
    applyStimulus(0, 0, 0, 1, 16'h0000, 16'h0200);
    tick();
    checkOutput("ben brp on z", {15'd0, BEN}, 16'd0);
    checkAll("ben seq");

    // Hold: no loads while BUS and IR toggle.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1'($urandom), 0, 0, 16'($urandom), 16'($urandom));
      tick();
      checkAll("hold");
    end

    // Same-cycle visibility of a write to R2.
    applyStimulus(1, 0, 0, 0, 16'h1234, 16'h0400);
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("bypass same cycle", regOut[2], 16'h1234);
`else
    checkOutput("no bypass same cycle", regOut[2], mReg[2]);
`endif
    checkOutput("bypass other reg", regOut[3], mReg[3]);
    tick();
    checkOutput("write R2 after edge", regOut[2], 16'h1234);

    // Randomized mix of all loads against the model.
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom), 16'($urandom));
      tick();
      checkAll("random");
    end

    applyStimulus(0, 0, 0, 0, 16'h0000, 16'h0000);
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
